// File: rtl/mem_access_unit32.sv
// Load/store initiator for a 32-bit word memory; sub-word stores are read-modify-write.
// IDLE: accept request | READ: fetch word | WRITE: store merged word | RESP: hold response
module mem_access_unit32 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_req_is_store,
    input  logic [1:0]  in_req_size,
    input  logic        in_req_unsigned,
    input  logic [31:0] in_req_address,
    input  logic [31:0] in_req_data,
    output logic        out_resp_valid,
    input  logic        in_resp_ready,
    output logic [31:0] out_resp_data,
    output logic        out_resp_exception,
    output logic [3:0]  out_resp_cause,
    output logic [31:0] out_mem_read_address,
    input  logic [31:0] in_mem_read_data,
    input  logic        in_mem_read_exception,
    output logic        out_mem_write_enable,
    output logic [31:0] out_mem_write_address,
    output logic [31:0] out_mem_write_data,
    input  logic        in_mem_write_exception
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        store_q;
    logic [31:0] data_q;
    logic [31:0] rd_addr_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        we_q;
    logic [31:0] resp_data_q;
    logic        resp_exc_q;
    logic [3:0]  resp_cause_q;

    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    assign misaligned = ((in_req_size == 2'd1) && in_req_address[0])
                     || ((in_req_size == 2'd2) && (in_req_address[1:0] != 2'b00))
                     || (in_req_size == 2'd3);

    always_comb begin
        ld_byte = in_mem_read_data[{lane_q, 3'b000} +: 8];
        ld_half = in_mem_read_data[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    load_d = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    load_d = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_d = in_mem_read_data;
        endcase
        merge_d = in_mem_read_data;
        case (size_q)
            2'd0:    merge_d[{lane_q, 3'b000} +: 8] = data_q[7:0];
            2'd1:    merge_d[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merge_d = data_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            data_q       <= 32'b0;
            rd_addr_q    <= 32'b0;
            wr_addr_q    <= 32'b0;
            wr_data_q    <= 32'b0;
            we_q         <= 1'b0;
            resp_data_q  <= 32'b0;
            resp_exc_q   <= 1'b0;
            resp_cause_q <= 4'd0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_req_valid) begin
                        lane_q  <= in_req_address[1:0];
                        size_q  <= in_req_size;
                        uns_q   <= in_req_unsigned;
                        store_q <= in_req_is_store;
                        data_q  <= in_req_data;
                        if (misaligned) begin
                            resp_data_q  <= 32'b0;
                            resp_exc_q   <= 1'b1;
                            resp_cause_q <= in_req_is_store ? 4'd6 : 4'd4;
                            state_q      <= RESP;
                        end else begin
                            // Read address is set here so memory data is valid throughout READ.
                            rd_addr_q <= {in_req_address[31:2], 2'b00};
                            state_q   <= READ;
                        end
                    end
                end
                READ: begin
                    if (in_mem_read_exception) begin
                        resp_data_q  <= 32'b0;
                        resp_exc_q   <= 1'b1;
                        resp_cause_q <= store_q ? 4'd7 : 4'd5;
                        state_q      <= RESP;
                    end else if (store_q) begin
                        we_q      <= 1'b1;
                        wr_addr_q <= rd_addr_q;
                        wr_data_q <= merge_d;
                        state_q   <= WRITE;
                    end else begin
                        resp_data_q  <= load_d;
                        resp_exc_q   <= 1'b0;
                        resp_cause_q <= 4'd0;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    resp_data_q  <= 32'b0;
                    resp_exc_q   <= in_mem_write_exception;
                    resp_cause_q <= in_mem_write_exception ? 4'd7 : 4'd0;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (in_resp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_req_ready         = (state_q == IDLE);
    assign out_resp_valid        = (state_q == RESP);
    assign out_resp_data         = resp_data_q;
    assign out_resp_exception    = resp_exc_q;
    assign out_resp_cause        = resp_cause_q;
    assign out_mem_read_address  = rd_addr_q;
    assign out_mem_write_enable  = we_q;
    assign out_mem_write_address = wr_addr_q;
    assign out_mem_write_data    = wr_data_q;

endmodule

// File: tb/tb_mem_access_unit32.sv
// Scoreboard bench for mem_access_unit32: directed requests push expected responses/writes,
// a negedge monitor pops and compares them.
module tb_mem_access_unit32;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic        in_req_is_store = 1'b0;
    logic [1:0]  in_req_size = 2'd0;
    logic        in_req_unsigned = 1'b0;
    logic [31:0] in_req_address = 32'b0;
    logic [31:0] in_req_data = 32'b0;
    logic        out_resp_valid;
    logic        in_resp_ready = 1'b1;
    logic [31:0] out_resp_data;
    logic        out_resp_exception;
    logic [3:0]  out_resp_cause;
    logic [31:0] out_mem_read_address;
    logic [31:0] in_mem_read_data;
    logic        in_mem_read_exception;
    logic        out_mem_write_enable;
    logic [31:0] out_mem_write_address;
    logic [31:0] out_mem_write_data;
    logic        in_mem_write_exception;

    logic        rd_fault = 1'b0;
    logic        wr_fault = 1'b0;
    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
        int          lat;
        int          acc;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    seen = 0;
    bit    got;

    mem_access_unit32 dut (
        .CLK(CLK), .RESET(RESET),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_req_is_store(in_req_is_store), .in_req_size(in_req_size),
        .in_req_unsigned(in_req_unsigned), .in_req_address(in_req_address),
        .in_req_data(in_req_data),
        .out_resp_valid(out_resp_valid), .in_resp_ready(in_resp_ready),
        .out_resp_data(out_resp_data), .out_resp_exception(out_resp_exception),
        .out_resp_cause(out_resp_cause),
        .out_mem_read_address(out_mem_read_address), .in_mem_read_data(in_mem_read_data),
        .in_mem_read_exception(in_mem_read_exception),
        .out_mem_write_enable(out_mem_write_enable), .out_mem_write_address(out_mem_write_address),
        .out_mem_write_data(out_mem_write_data), .in_mem_write_exception(in_mem_write_exception)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign in_mem_read_data       = mem[out_mem_read_address[9:2]];
    assign in_mem_read_exception  = rd_fault;
    assign in_mem_write_exception = wr_fault;

    always @(posedge CLK)
        if (out_mem_write_enable && !wr_fault) mem[out_mem_write_address[9:2]] <= out_mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: responses and write strobes are compared against the scoreboard queues.
    always @(negedge CLK) begin
        resp_t r;
        wr_t   w;
        if (RESET && out_resp_valid) begin
            if (rq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: data 0x%08h cause %0d", out_resp_data, out_resp_cause);
            end else begin
                if (!seen) begin
                    chk("resp_latency", cyc - rq[0].acc + 1, rq[0].lat);
                    seen = 1;
                end
                chk("resp_data", out_resp_data, rq[0].data);
                chk("resp_exception", {31'b0, out_resp_exception}, {31'b0, rq[0].exc});
                chk("resp_cause", {28'b0, out_resp_cause}, {28'b0, rq[0].cause});
                if (in_resp_ready) begin
                    r = rq.pop_front();
                    seen = 0;
                end
            end
        end
        if (RESET && out_mem_write_enable) begin
            if (wq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", out_mem_write_address, out_mem_write_data);
            end else begin
                w = wq.pop_front();
                chk("write_addr", out_mem_write_address, w.addr);
                chk("write_data", out_mem_write_data, w.data);
                chk("write_read_addr", out_mem_read_address, w.addr);
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] ed, input bit ex,
                         input logic [3:0] ca, input int lat, input bit rf, input bit wf,
                         input bit hw, input logic [31:0] ew, input bit er);
        bit rdy;
        bit acc;
        resp_t r;
        wr_t   w;
        @(posedge CLK); #1;
        in_req_is_store = st; in_req_size = sz; in_req_unsigned = un;
        in_req_address = addr; in_req_data = wdata;
        rd_fault = rf; wr_fault = wf;
        in_req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge CLK);
            rdy = out_req_ready;
            @(posedge CLK); #1;
            if (rdy) acc = 1;
        end
        in_req_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: request at 0x%08h not accepted, expected acceptance", addr);
        end else begin
            if (er) begin
                r.data = ed; r.exc = ex; r.cause = ca; r.lat = lat; r.acc = cyc;
                rq.push_back(r);
            end
            if (hw) begin
                w.addr = {addr[31:2], 2'b00}; w.data = ew;
                wq.push_back(w);
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && rq.size() != 0; i++) @(negedge CLK);
        if (rq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout: %0d responses outstanding, expected 0", rq.size());
            rq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'b0;
        mem[32'h100 >> 2] = 32'h80F01234;

        @(negedge CLK);
        chk("rst_req_ready", {31'b0, out_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, out_resp_valid}, 32'd0);
        chk("rst_write_enable", {31'b0, out_mem_write_enable}, 32'd0);
        chk("rst_resp_data", out_resp_data, 32'd0);
        chk("rst_read_addr", out_mem_read_address, 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;

        //    st  sz   un addr         wdata         exp_data      ex ca lat rf wf hw ew            er
        issue(0, 2'd0, 0, 32'h102, 32'h0,        32'hFFFFFFF0, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();
        issue(0, 2'd0, 1, 32'h102, 32'h0,        32'h000000F0, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();
        issue(0, 2'd1, 0, 32'h102, 32'h0,        32'hFFFF80F0, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();
        issue(0, 2'd2, 0, 32'h100, 32'h0,        32'h80F01234, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();
        issue(1, 2'd0, 0, 32'h101, 32'h000000AB, 32'h0,        0, 0, 3, 0, 0, 1, 32'h80F0AB34, 1); wait_done();
        issue(0, 2'd2, 0, 32'h102, 32'h0,        32'h0,        1, 4, 1, 0, 0, 0, 32'h0,        1); wait_done();
        issue(1, 2'd1, 0, 32'h103, 32'h1234,     32'h0,        1, 6, 1, 0, 0, 0, 32'h0,        1); wait_done();
        issue(0, 2'd3, 0, 32'h100, 32'h0,        32'h0,        1, 4, 1, 0, 0, 0, 32'h0,        1); wait_done();
        issue(0, 2'd2, 0, 32'h100, 32'h0,        32'h0,        1, 5, 2, 1, 0, 0, 32'h0,        1); wait_done();
        issue(1, 2'd2, 0, 32'h104, 32'h11223344, 32'h0,        1, 7, 3, 0, 1, 1, 32'h11223344, 1); wait_done();
        issue(0, 2'd1, 1, 32'h100, 32'h0,        32'h0000AB34, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();
        issue(1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'h0,        0, 0, 3, 0, 0, 1, 32'hBEEFAB34, 1); wait_done();
        issue(0, 2'd0, 0, 32'h103, 32'h0,        32'hFFFFFFBE, 0, 0, 2, 0, 0, 0, 32'h0,        1); wait_done();

        // Back-pressure: response held three cycles while a second request waits.
        in_resp_ready = 1'b0;
        issue(0, 2'd2, 0, 32'h100, 32'h0, 32'hBEEFAB34, 0, 0, 2, 0, 0, 0, 32'h0, 1);
        fork
            issue(0, 2'd0, 1, 32'h101, 32'h0, 32'h000000AB, 0, 0, 2, 0, 0, 0, 32'h0, 1);
            begin
                got = 0;
                for (int i = 0; i < 20 && !got; i++) begin
                    @(negedge CLK);
                    if (out_resp_valid) got = 1;
                end
                chk("bp_resp_seen", {31'b0, got}, 32'd1);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge CLK);
                    chk("bp_req_ready", {31'b0, out_req_ready}, 32'd0);
                end
                @(posedge CLK); #1 in_resp_ready = 1'b1;
            end
        join
        wait_done();

        // Reset while a store is in READ: nothing may be written or answered.
        issue(1, 2'd0, 0, 32'h100, 32'h00000055, 32'h0, 0, 0, 3, 0, 0, 0, 32'h0, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("mid_rst_req_ready", {31'b0, out_req_ready}, 32'd1);
        chk("mid_rst_write_enable", {31'b0, out_mem_write_enable}, 32'd0);
        chk("mid_rst_write_data", out_mem_write_data, 32'd0);
        chk("mid_rst_write_addr", out_mem_write_address, 32'd0);
        chk("mid_rst_resp_cause", {28'b0, out_resp_cause}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_rst_write_enable", {31'b0, out_mem_write_enable}, 32'd0);
            chk("post_rst_resp_valid", {31'b0, out_resp_valid}, 32'd0);
            chk("post_rst_req_ready", {31'b0, out_req_ready}, 32'd1);
        end
        chk("mem_untouched", mem[32'h100 >> 2], 32'hBEEFAB34);
        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("write_queue_empty", wq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit32.md
# mem_access_unit32

Processor-side load/store initiator for the 32-bit word memory. It accepts byte, half-word and word loads and stores from the execute stage over a valid/ready handshake, and issues whole-word requests on the memory's read and write ports. Sub-word stores are performed as read-modify-write. Results and exceptions are returned over a second valid/ready handshake.

## Interface
Parameters:
- none

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RESET  input  1  asynchronous, active-low reset
- in_req_valid  input  1  request present
- out_req_ready  output  1  unit can accept a request; equals (state == IDLE)
- in_req_is_store  input  1  1 selects store, 0 selects load
- in_req_size  input  2  0 selects byte, 1 half-word, 2 word; 3 is illegal
- in_req_unsigned  input  1  loads only; 1 zero-extends, 0 sign-extends
- in_req_address  input  32  byte address
- in_req_data  input  32  store data, right-aligned
- out_resp_valid  output  1  response present
- in_resp_ready  input  1  consumer accepts the response
- out_resp_data  output  32  load result; 0 for stores and exceptions
- out_resp_exception  output  1  request faulted
- out_resp_cause  output  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault; 0 if no exception
- out_mem_read_address  output  32  word-aligned address
- in_mem_read_data  input  32  combinational read data for out_mem_read_address
- in_mem_read_exception  input  1  read fault
- out_mem_write_enable  output  1  write strobe
- out_mem_write_address  output  32  word-aligned address
- out_mem_write_data  output  32  merged word to write
- in_mem_write_exception  input  1  write fault

## Operation
- The FSM has four states: IDLE, READ, WRITE and RESP.
- **Acceptance:** a request is accepted when in_req_valid is 1 and out_req_ready is 1. On acceptance the unit latches address, size, unsigned, is_store and data.
- **Alignment check at acceptance.** A request is misaligned if any of these holds:
  - size 1 with address[0] = 1
  - size 2 with address[1:0] != 0
  - size 3
- **IDLE:**
  - Misaligned request: go to RESP with cause 4 (load) or 6 (store).
  - Aligned request: go to READ.
- **READ:**
  - Drive out_mem_read_address = {addr[31:2], 2'b00}.
  - Register in_mem_read_data into the word register.
  - If in_mem_read_exception is 1: go to RESP with cause 5 (load) or 7 (store).
  - Else, for a load: extract the result and go to RESP.
  - Else, for a store: go to WRITE.
- **Load extraction:** the lane is selected by addr[1:0].
  - Byte: word[8*lane+7 : 8*lane].
  - Half: word[16*addr[1]+15 : 16*addr[1]].
  - Byte and half results are extended to 32 bits per in_req_unsigned.
- **Store merge:**
  - Byte: replace lane addr[1:0] with data[7:0].
  - Half: replace half addr[1] with data[15:0].
  - Word: write data unchanged.
- **WRITE:**
  - out_mem_write_enable = 1 for exactly this one cycle.
  - out_mem_write_address = out_mem_read_address = the word address. The read address is held equal to the write address because the memory's write path indexes by the read address.
  - If in_mem_write_exception is 1: cause 7. Either way, go to RESP.
- **RESP:**
  - out_resp_valid = 1; data, exception and cause are held stable.
  - When in_resp_ready is 1, go to IDLE.
- **Port defaults:** outside READ and WRITE, out_mem_read_address holds its last value and out_mem_write_enable = 0.
- **Reset (RESET = 0), asynchronous:**
  - State goes to IDLE.
  - out_resp_valid, out_mem_write_enable, out_resp_exception = 0.
  - out_resp_data, out_resp_cause, both memory addresses and out_mem_write_data = 0.
  - out_req_ready = 1.
- **Reset mid-operation:** the operation is abandoned. No memory write and no response are produced for it.

## Timing
Cycle 0 is the acceptance edge.
- Misaligned request: out_resp_valid = 1 in cycle 1.
- Load: READ in cycle 1, out_resp_valid in cycle 2.
- Store: READ in cycle 1, write strobe in cycle 2, out_resp_valid in cycle 3.
- Read fault: out_resp_valid in cycle 2, with no write.
- Back-pressure: RESP persists while in_resp_ready = 0. A new request is accepted no earlier than the cycle after the response handshake.
- One request is outstanding at most; there is no pipelining.

## Test plan
Preload memory word 0x100 = 0x80F01234.
- **Sub-word loads:**
  - Load byte at 0x102, signed -> 0xFFFFFFF0 in cycle 2.
  - Load byte at 0x102, unsigned -> 0x000000F0.
  - Load half at 0x102, signed -> 0xFFFF80F0.
  - Load word at 0x100 -> 0x80F01234.
- **Byte store:** store byte at 0x101, data 0x000000AB.
  - Cycle 2: out_mem_write_enable = 1, address 0x100, data 0x80F0AB34; both memory addresses = 0x100.
  - Cycle 3: response, no exception.
- **Misaligned requests:**
  - Load word at 0x102 -> response in cycle 1 with exception = 1 and cause 4; no memory write.
  - Store half at 0x103 -> cause 6.
- **Faults:**
  - Load with in_mem_read_exception = 1 in READ -> cause 5.
  - Store with in_mem_write_exception = 1 in WRITE -> cause 7, with exactly one write strobe.
- **Back-pressure:** in_resp_ready = 0 for 3 cycles after a load.
  - Response data stays stable and out_req_ready stays 0.
  - A new in_req_valid is not accepted until after the handshake.
- **Reset mid-store:** assert RESET = 0 during READ of a store.
  - out_mem_write_enable never rises and out_resp_valid stays 0.
  - out_req_ready = 1 after release.
